// File: rtl/bcd_score_accum_pkg.sv
// Shared types and constants for the BCD score accumulator.
package score_pkg;

    typedef logic [3:0]        bcd_t;
    typedef logic signed [1:0] carry_t;

    // Inter-digit carry, 2-bit two's complement; 2'b10 is never produced.
    localparam carry_t CARRY_NEG  = 2'b11;
    localparam carry_t CARRY_ZERO = 2'b00;
    localparam carry_t CARRY_POS  = 2'b01;

    localparam int DELTA_MIN = -8;
    localparam int DELTA_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_score_accum_if.sv
// Delta handshake and score/status bus between the game logic and the accumulator.
interface bcd_score_accum_if #(
    parameter int NDIGITS = 4
);
    logic                   delta_valid;
    logic [4:0]             delta;
    logic                   ready;
    logic [4*NDIGITS-1:0]   score;
    logic                   done;
    logic                   oflow;
    logic                   uflow;
    logic                   err;

    modport master (
        output delta_valid, delta,
        input  ready, score, done, oflow, uflow, err
    );

    modport slave (
        input  delta_valid, delta,
        output ready, score, done, oflow, uflow, err
    );
endinterface

// File: rtl/bcd_score_accum_digit_step.sv
// One BCD digit plus a signed incoming value (-8..+8), producing the new
// digit and a {-1,0,+1} carry for the next digit up.
module bcd_digit_step
    import score_pkg::*;
(
    input  bcd_t              curr_i,
    input  logic signed [4:0] in_i,
    output bcd_t              next_o,
    output carry_t            carry_o
);
    logic signed [5:0] sum;
    logic signed [5:0] adj;

    // Sum spans -8..17, so a single +/-10 correction always lands in 0..9.
    always_comb begin
        sum = $signed({2'b00, curr_i}) + $signed({in_i[4], in_i});
        adj = sum;
        carry_o = CARRY_ZERO;
        if (sum < 0) begin
            adj     = sum + 6'sd10;
            carry_o = CARRY_NEG;
        end else if (sum > 6'sd9) begin
            adj     = sum - 6'sd10;
            carry_o = CARRY_POS;
        end
        next_o = adj[3:0];
    end
endmodule

// File: rtl/bcd_score_accum.sv
// Sequential BCD score accumulator: applies one signed delta per transaction,
// one digit per cycle LSD first, saturating at zero and at all-nines.
module bcd_score_accum
    import score_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    bcd_score_accum_if.slave   bus
);
    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIGITS - 1);

    state_t                    state_q, state_d;
    bcd_t [NDIGITS-1:0]        digits_q, digits_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic signed [4:0]         carry_q, carry_d;
    logic                      oflow_q, oflow_d;
    logic                      uflow_q, uflow_d;
    logic                      err_q, err_d;

    logic signed [4:0]         delta_s;
    logic                      delta_legal;
    bcd_t                      step_next;
    carry_t                    step_carry;

    assign delta_s     = $signed(bus.delta);
    assign delta_legal = (delta_s >= DELTA_MIN) && (delta_s <= DELTA_MAX);

    // Single digit adder shared across all digit positions.
    bcd_digit_step u_step (
        .curr_i  (digits_q[idx_q]),
        .in_i    (carry_q),
        .next_o  (step_next),
        .carry_o (step_carry)
    );

    // State, score and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            digits_q <= '0;
            idx_q    <= '0;
            carry_q  <= '0;
            oflow_q  <= 1'b0;
            uflow_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            oflow_q  <= oflow_d;
            uflow_q  <= uflow_d;
            err_q    <= err_d;
        end
    end

    // Next-state: accept in IDLE, ripple in RUN, one-cycle report in DONE.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        oflow_d  = oflow_q;
        uflow_d  = uflow_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.delta_valid) begin
                    if (delta_legal) begin
                        carry_d = delta_s;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                digits_d[idx_q] = step_next;
                if (step_carry == CARRY_ZERO) begin
                    state_d = DONE;
                end else if (idx_q == IDX_LAST) begin
                    // Ran off the top digit: clamp instead of wrapping.
                    state_d = DONE;
                    if (step_carry == CARRY_POS) begin
                        digits_d = {NDIGITS{4'd9}};
                        oflow_d  = 1'b1;
                    end else if (step_carry == CARRY_NEG) begin
                        digits_d = '0;
                        uflow_d  = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    carry_d = {{3{step_carry[1]}}, step_carry};
                end
            end
            DONE: begin
                oflow_d = 1'b0;
                uflow_d = 1'b0;
                err_d   = 1'b0;
                carry_d = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.oflow = (state_q == DONE) && oflow_q;
    assign bus.uflow = (state_q == DONE) && uflow_q;
    assign bus.err   = (state_q == DONE) && err_q;
    assign bus.score = digits_q;
endmodule
